avr_uart_tx: RTL
================

// Module: avr_uart_tx
// PURPOSE
//  - UART transmitter from the FPGA to the AVR. Drives avr_rx, the FPGA Tx line to the AVR's serial bridge.
//  - Honours the AVR flow-control input avr_rx_busy.
//  - A small FIFO decouples producers in mojo_top from the bit timing.
//  - Frame format is 8N1: start bit, 8 data bits LSB first, one stop bit, idle high.
// PARAMETERS
//  CLK_PER_BIT  100  clock cycles per bit (50 MHz / 500 kbaud); legal range >= 2
//  FIFO_DEPTH   4    byte FIFO entries; power of 2, >= 2
//  CNT_W        $clog2(FIFO_DEPTH+1)  localparam, width of fifo_count
// PORTS
//  clk         in   1      50 MHz system clock
//  rst         in   1      synchronous reset, active high
//  data        in   8      byte to send
//  new_data    in   1      push strobe; byte accepted on rising edge when new_data & ready
//  ready       out  1      FIFO not full (combinational from count)
//  block       in   1      connect to avr_rx_busy; asynchronous, high = AVR cannot accept
//  tx          out  1      serial out, connect to avr_rx; registered
//  busy        out  1      high while a frame is on the line (START..STOP)
//  fifo_count  out  CNT_W  bytes waiting in the FIFO (excludes the byte in flight)
// BEHAVIOUR
//  Reset
//  - On rst, all outputs take their reset values on the next edge:
//    tx=1, busy=0, ready=1, fifo_count=0, FSM=IDLE, FIFO flushed.
//  - Reset mid-frame aborts the frame; no partial stop bit is sent.
//  Flow-control synchronizer
//  - block passes through a 2-flop synchronizer, giving blk_s.
//  - Only blk_s is used; a change on block takes effect 2 edges later.
//  FIFO
//  - Push when new_data & ready.
//  - Push and pop in the same cycle are allowed when not full; count is unchanged.
//  - When full, a push is rejected even if a pop occurs that cycle.
//  - A rejected byte is dropped silently.
//  - Output order is strict FIFO; pointers wrap modulo FIFO_DEPTH.
//  FSM states: IDLE, START, DATA, STOP
//  - Bit timer counts 0..CLK_PER_BIT-1.
//  - Bit index counts 0..7, in DATA only.
//  - IDLE: tx=1, busy=0.
//    - If fifo_count!=0 and blk_s==0: pop, load shifter, tx<=0, go to START.
//  - START: tx=0 for CLK_PER_BIT cycles, then tx<=shifter[0], go to DATA.
//  - DATA: each bit lasts CLK_PER_BIT cycles; shift right.
//    - After bit 7 completes: tx<=1, go to STOP.
//  - STOP: tx=1 for exactly CLK_PER_BIT cycles, then:
//    - If fifo_count!=0 and blk_s==0: pop and go straight to START, with no idle gap.
//    - Otherwise go to IDLE.
//  - busy=1 in START, DATA and STOP.
//  Latency
//  - Byte accepted at edge E into an empty FIFO with the FSM in IDLE and blk_s=0: tx falls at edge E+1.
//  Blocking
//  - blk_s is sampled only at frame start (the IDLE exit or the STOP end).
//  - Asserting block mid-frame never truncates or stretches the current frame.
//  - While blk_s=1, the FSM holds IDLE with tx=1 and the FIFO keeps accepting until full.
//  Line timing
//  - Frame length is exactly 10*CLK_PER_BIT cycles.
//  - tx never glitches; it changes only at bit boundaries.
// TESTING (CLK_PER_BIT=4, FIFO_DEPTH=4 unless noted)
//  T1 Single byte
//     - Stimulus: rst for 2 cycles; push 0xA5 at edge E.
//     - Required: tx=0 from E+1 for 4 cycles.
//     - Required: then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1 for 4 cycles.
//     - Required: busy=0 at E+41; fifo_count returns to 0 at E+1.
//  T2 Fill while blocked
//     - Stimulus: block=1; push 0x01..0x05 on consecutive cycles.
//     - Required: ready falls after the 4th push and 0x05 is dropped; fifo_count=4; tx stays 1.
//     - Stimulus: release block.
//     - Required: the first start bit falls 3 edges after block falls, where it is sampled.
//     - Required: 4 back-to-back frames 0x01..0x04, each 40 cycles, no idle gap.
//  T3 Block mid-frame
//     - Stimulus: 2 bytes queued; raise block during DATA of frame 1.
//     - Required: frame 1 completes intact; tx=1 and busy=0 afterwards.
//     - Stimulus: drop block.
//     - Required: frame 2 starts 3 edges later.
//  T4 Reset mid-frame
//     - Stimulus: assert rst during bit 3 of a frame with 2 bytes queued.
//     - Required: on the next edge tx=1, busy=0, fifo_count=0, ready=1; no further frames.
//  T5 Full with simultaneous pop
//     - Stimulus: FIFO full, push asserted on the STOP-end edge that pops.
//     - Required: push rejected; fifo_count goes 4->3.
//     - Required: next cycle ready=1, and a push there is accepted.
//  T6 Timing sweep
//     - Stimulus: CLK_PER_BIT=2 and CLK_PER_BIT=100 with random bytes.
//     - Required: a scoreboard receiver decodes every byte.
//     - Required: frame length is exactly 10*CLK_PER_BIT cycles.

Source files
------------

// File: rtl/avr_uart_tx.sv
// 8N1 UART transmitter toward the AVR serial bridge, with a small byte FIFO and
// avr_rx_busy flow control sampled only at frame boundaries.
module avr_uart_tx #(
  parameter int unsigned CLK_PER_BIT = 100,
  parameter int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data,
  input  logic             new_data,
  output logic             ready,
  input  logic             block,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned TW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [TW-1:0] TimerLast = TW'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CountFull = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state;
  logic [TW-1:0]    bit_timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shifter;
  logic             timer_done;
  logic             frame_start;
  logic             pop;
  logic             push;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;

  logic             blk_meta;
  logic             blk_s;

  // Synchronizer resets to blocked so nothing is sent until the AVR is seen ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_meta <= 1'b1;
      blk_s    <= 1'b1;
    end else begin
      blk_meta <= block;
      blk_s    <= blk_meta;
    end
  end

  assign ready      = (count != CountFull);
  assign fifo_count = count;
  assign push       = new_data & ready;

  assign timer_done  = (bit_timer == TimerLast);
  // Flow control is honoured only where a new frame may begin.
  assign frame_start = (state == StIdle) || ((state == StStop) && timer_done);
  assign pop         = frame_start && (count != '0) && !blk_s;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      tx        <= 1'b1;
      busy      <= 1'b0;
      bit_timer <= '0;
      bit_idx   <= '0;
      shifter   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          tx        <= 1'b1;
          busy      <= 1'b0;
          bit_timer <= '0;
          if (pop) begin
            shifter <= mem[rd_ptr];
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= StStart;
          end
        end
        StStart: begin
          if (timer_done) begin
            bit_timer <= '0;
            bit_idx   <= '0;
            tx        <= shifter[0];
            state     <= StData;
          end else begin
            bit_timer <= bit_timer + TW'(1);
          end
        end
        StData: begin
          if (timer_done) begin
            bit_timer <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= StStop;
            end else begin
              shifter <= shifter >> 1;
              tx      <= shifter[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_timer <= bit_timer + TW'(1);
          end
        end
        StStop: begin
          if (timer_done) begin
            bit_timer <= '0;
            if (pop) begin
              // Back-to-back frame: start bit follows the stop bit directly.
              shifter <= mem[rd_ptr];
              tx      <= 1'b0;
              state   <= StStart;
            end else begin
              busy  <= 1'b0;
              state <= StIdle;
            end
          end else begin
            bit_timer <= bit_timer + TW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
